lag_sensor_timer: RTL and testbench

//  Measures display latency for the lag tester. Consumes the video VSync from the video timing generator
//  and the photodiode input on the open-drain user port.
//  On arm, waits for the next frame start, raises flash so the renderer paints the test patch,
//  and counts microseconds until the debounced sensor reports light.
//  The measured count is reported to the on-screen result display.

---
 rtl/lag_sensor_timer.sv | 142 ++++++++++++++
 tb/tb_lag_sensor_timer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lag_sensor_timer.sv
// rtl/lag_sensor_timer.sv - display latency timer: vsync-triggered flash, debounced photodiode, microsecond count
module lag_sensor_timer #(
  parameter int US_DIV     = 48,
  parameter int DEB_CYC    = 16,
  parameter int TIMEOUT_US = 200000,
  parameter int CNT_W      = 18,
  parameter bit SENSOR_ACT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vsync,
  input  logic             sensor_in,
  input  logic             arm,
  input  logic             abort,
  output logic             flash,
  output logic             busy,
  output logic             sensor_lit,
  output logic [CNT_W-1:0] result_us,
  output logic             result_valid,
  output logic             timeout
);

  localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_US);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(US_DIV - 1);
  localparam logic [DW-1:0]    DEB_MAX   = DW'(DEB_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_MEASURE, S_DONE} state_t;

  state_t            state, state_nx;
  logic              sync_1, sync_2;
  logic              lit_sample;
  logic [DW-1:0]     deb_cnt;
  logic              vsync_q;
  logic              vs_rise;
  logic [PW-1:0]     presc;
  logic [CNT_W-1:0]  us_cnt;
  logic              hit_detect;
  logic              hit_timeout;

  // Two-flop synchronizer; cleared to the dark level so reset never looks like light.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= ~SENSOR_ACT;
      sync_2 <= ~SENSOR_ACT;
    end else begin
      sync_1 <= sensor_in;
      sync_2 <= sync_1;
    end
  end

  assign lit_sample = (sync_2 == SENSOR_ACT);

  // Debounce: flip the level after DEB_CYC consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt    <= '0;
      sensor_lit <= 1'b0;
    end else if (lit_sample == sensor_lit) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_MAX) begin
      deb_cnt    <= '0;
      sensor_lit <= lit_sample;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Delayed vsync for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vsync_q <= 1'b0;
    else          vsync_q <= vsync;
  end

  assign vs_rise = vsync & ~vsync_q;

  // Microsecond prescaler and counter; held at zero outside MEASURE so entry starts from 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (state != S_MEASURE) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (presc == PRESC_MAX) begin
      presc  <= '0;
      us_cnt <= (us_cnt >= TIMEOUT_C) ? TIMEOUT_C : us_cnt + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Detection outranks timeout when both happen on the same cycle; abort outranks both.
  assign hit_detect  = (state == S_MEASURE) && !abort && sensor_lit;
  assign hit_timeout = (state == S_MEASURE) && !abort && !sensor_lit && (us_cnt == TIMEOUT_C);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (arm) state_nx = S_WAIT_VS;
      S_WAIT_VS: begin
        if (abort)                       state_nx = S_IDLE;
        else if (vs_rise && !sensor_lit) state_nx = S_MEASURE;
      end
      S_MEASURE: begin
        if (abort)                         state_nx = S_IDLE;
        else if (hit_detect || hit_timeout) state_nx = S_DONE;
      end
      S_DONE:    if (abort || !sensor_lit) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    flash = (state == S_MEASURE);
    busy  = (state != S_IDLE);
  end

  // Result capture and one-cycle completion pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_us    <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      result_valid <= hit_detect;
      timeout      <= hit_timeout;
      if (hit_detect)       result_us <= us_cnt;
      else if (hit_timeout) result_us <= TIMEOUT_C;
    end
  end

endmodule

// File: tb/tb_lag_sensor_timer.sv
// tb/tb_lag_sensor_timer.sv - directed self-checking bench for lag_sensor_timer
module tb_lag_sensor_timer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vsync = 1'b0;
  logic       sensor_in = 1'b1;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic       flash, busy, sensor_lit, result_valid, timeout;
  logic [7:0] result_us;

  int total = 0;
  int bad = 0;

  lag_sensor_timer #(
    .US_DIV(4), .DEB_CYC(3), .TIMEOUT_US(100), .CNT_W(8), .SENSOR_ACT(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .sensor_in(sensor_in),
    .arm(arm), .abort(abort), .flash(flash), .busy(busy), .sensor_lit(sensor_lit),
    .result_us(result_us), .result_valid(result_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1; @(negedge clk); arm = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; @(negedge clk); abort = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1; @(negedge clk); vsync = 1'b0;
  endtask

  // Returns on the first negedge with flash high (MEASURE entered on the preceding posedge).
  task automatic wait_flash(input string tag);
    int seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (flash) begin seen = 1; break; end
      @(negedge clk);
    end
    chk(tag, seen, 1);
  endtask

  // Sensor goes light 160 clk after MEASURE entry: sampled on edge +161, debounced after +165,
  // captured on +166 with us_cnt = 165/4 = 41.
  task automatic measure_basic(input string tag);
    int pulses = 0;
    int res = 0;
    pulse_arm();
    pulse_vsync();
    wait_flash({tag, "_flash"});
    cycles(160);
    sensor_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_valid) begin pulses++; res = int'(result_us); end
    end
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_result"}, res, 41);
    chk({tag, "_flash_off"}, int'(flash), 0);
    chk({tag, "_busy_done"}, int'(busy), 1);
    sensor_in = 1'b1;
    cycles(10);
    chk({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  initial begin
    int n_to, n_rv, to_cyc, lit_seen;

    cycles(2);
    chk("rst_flash", int'(flash), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_lit", int'(sensor_lit), 0);
    chk("rst_result", int'(result_us), 0);
    chk("rst_pulses", int'(result_valid | timeout), 0);
    reset_n = 1'b1;
    cycles(5);
    chk("rst_busy_after", int'(busy), 0);

    // 1 basic measurement
    measure_basic("t1");

    // 2 timeout
    pulse_arm();
    pulse_vsync();
    wait_flash("t2_flash");
    n_to = 0; n_rv = 0; to_cyc = 0;
    for (int i = 1; i <= 420; i++) begin
      @(negedge clk);
      if (timeout) begin n_to++; to_cyc = i; end
      if (result_valid) n_rv++;
    end
    chk("t2_to_pulses", n_to, 1);
    chk("t2_to_cycle", to_cyc, 401);
    chk("t2_rv", n_rv, 0);
    chk("t2_result", int'(result_us), 100);
    chk("t2_busy", int'(busy), 0);

    // 3 glitch rejection
    pulse_arm();
    pulse_vsync();
    wait_flash("t3_flash");
    lit_seen = 0; n_rv = 0;
    for (int i = 0; i < 60; i++) begin
      sensor_in = ((i % 10) < 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (sensor_lit) lit_seen++;
      if (result_valid) n_rv++;
    end
    sensor_in = 1'b1;
    chk("t3_lit", lit_seen, 0);
    chk("t3_rv", n_rv, 0);
    chk("t3_flash_still", int'(flash), 1);
    pulse_abort();
    chk("t3_abort_idle", int'(busy), 0);

    // 4 lit at frame start
    sensor_in = 1'b0;
    cycles(10);
    chk("t4_lit", int'(sensor_lit), 1);
    pulse_arm();
    for (int k = 0; k < 3; k++) begin
      pulse_vsync();
      cycles(3);
      chk("t4_no_flash", int'(flash), 0);
    end
    chk("t4_waiting", int'(busy), 1);
    sensor_in = 1'b1;
    cycles(10);
    chk("t4_dark", int'(sensor_lit), 0);
    chk("t4_still_wait", int'(flash), 0);
    pulse_vsync();
    chk("t4_flash", int'(flash), 1);
    pulse_abort();
    chk("t4_abort_idle", int'(busy), 0);

    // 5 abort and re-arm
    pulse_arm();
    pulse_vsync();
    wait_flash("t5_flash");
    n_rv = 0; n_to = 0;
    for (int i = 0; i < 20; i++) begin
      arm = (i == 5);
      @(negedge clk);
      if (result_valid) n_rv++;
      if (timeout) n_to++;
    end
    arm = 1'b0;
    chk("t5_arm_ignored", int'(flash), 1);
    pulse_abort();
    chk("t5_idle", int'(busy), 0);
    chk("t5_flash_off", int'(flash), 0);
    cycles(3);
    chk("t5_pulses", n_rv + n_to + int'(result_valid) + int'(timeout), 0);
    chk("t5_result_kept", int'(result_us), 100);
    pulse_arm();
    chk("t5_rearm", int'(busy), 1);
    pulse_abort();

    // 6 asynchronous reset mid-measurement
    pulse_arm();
    pulse_vsync();
    wait_flash("t6_flash");
    cycles(30);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_flash", int'(flash), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_result", int'(result_us), 0);
    chk("t6_pulses", int'(result_valid | timeout | sensor_lit), 0);
    cycles(3);
    reset_n = 1'b1;
    cycles(3);
    measure_basic("t6m");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
